// File: rtl/cache_dm_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache with byte-masked stores and a
// whole-cache flush. Line storage is plain registers; one line-wide memory port.
`timescale 1ns/1ps

module cache_dm_wb #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned CPU_DATA_WIDTH = 32,
    parameter int unsigned INDEX_WIDTH    = 2,
    parameter int unsigned OFFSET_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            cpu_req_valid,
    output logic                            cpu_req_ready,
    input  logic [ADDR_WIDTH-1:0]           cpu_req_addr,
    input  logic                            cpu_req_write,
    input  logic [CPU_DATA_WIDTH-1:0]       cpu_req_wdata,
    input  logic [CPU_DATA_WIDTH/8-1:0]     cpu_req_wmask,
    input  logic                            cpu_flush,
    output logic                            cpu_flush_done,
    output logic                            cpu_resp_valid,
    output logic [CPU_DATA_WIDTH-1:0]       cpu_resp_rdata,
    output logic                            cpu_resp_hit,

    output logic                            mem_w_valid,
    input  logic                            mem_w_ready,
    output logic [ADDR_WIDTH-1:0]           mem_w_addr,
    output logic [(8<<OFFSET_WIDTH)-1:0]    mem_w_data,
    output logic [(1<<OFFSET_WIDTH)-1:0]    mem_w_wmask,
    output logic                            mem_r_valid,
    input  logic                            mem_r_ready,
    output logic [ADDR_WIDTH-1:0]           mem_r_addr,
    input  logic                            mem_rdata_valid,
    input  logic [(8<<OFFSET_WIDTH)-1:0]    mem_rdata
);

    localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int unsigned NUM_LINES  = 1 << INDEX_WIDTH;
    localparam int unsigned MASK_WIDTH = CPU_DATA_WIDTH / 8;
    localparam int unsigned WORD_OFF   = $clog2(MASK_WIDTH);
    localparam int unsigned WSEL_WIDTH = OFFSET_WIDTH - WORD_OFF;
    localparam int unsigned NUM_WORDS  = 1 << WSEL_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = {INDEX_WIDTH{1'b1}};

    typedef logic [NUM_WORDS-1:0][CPU_DATA_WIDTH-1:0] line_t;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWb,
        StRreq,
        StRwait,
        StFlush,
        StFlushNext
    } state_e;

    state_e                     state_q, state_d;
    line_t                      data_q [NUM_LINES];
    line_t                      data_d [NUM_LINES];
    logic [TAG_WIDTH-1:0]       tag_q  [NUM_LINES];
    logic [TAG_WIDTH-1:0]       tag_d  [NUM_LINES];
    logic [NUM_LINES-1:0]       valid_q, valid_d;
    logic [NUM_LINES-1:0]       dirty_q, dirty_d;

    logic [INDEX_WIDTH-1:0]     idx_q, idx_d;
    logic [TAG_WIDTH-1:0]       req_tag_q, req_tag_d;
    logic [WSEL_WIDTH-1:0]      wsel_q, wsel_d;
    logic                       write_q, write_d;
    logic [CPU_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0]      wmask_q, wmask_d;
    logic                       flush_q, flush_d;
    // Set once a refill has landed so the replayed lookup still reports the original miss.
    logic                       replay_q, replay_d;

    line_t                      cur_line;
    line_t                      merged_line;
    logic [CPU_DATA_WIDTH-1:0]  cur_word;
    logic [CPU_DATA_WIDTH-1:0]  merged_word;
    logic                       hit;
    logic                       victim_dirty;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_req_addr[WORD_OFF-1:0];

    always_comb begin
        cur_line     = data_q[idx_q];
        cur_word     = cur_line[wsel_q];
        merged_word  = cur_word;
        for (int b = 0; b < int'(MASK_WIDTH); b++) begin
            if (wmask_q[b]) begin
                merged_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
        merged_line          = cur_line;
        merged_line[wsel_q]  = merged_word;
        hit                  = valid_q[idx_q] && (tag_q[idx_q] == req_tag_q);
        victim_dirty         = valid_q[idx_q] && dirty_q[idx_q];
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        idx_d     = idx_q;
        req_tag_d = req_tag_q;
        wsel_d    = wsel_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        flush_d   = flush_q;
        replay_d  = replay_q;

        unique case (state_q)
            StIdle: begin
                if (cpu_flush) begin
                    flush_d = 1'b1;
                    idx_d   = '0;
                    state_d = StFlush;
                end else if (cpu_req_valid) begin
                    idx_d     = cpu_req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
                    req_tag_d = cpu_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                    wsel_d    = cpu_req_addr[WORD_OFF +: WSEL_WIDTH];
                    write_d   = cpu_req_write;
                    wdata_d   = cpu_req_wdata;
                    wmask_d   = cpu_req_wmask;
                    replay_d  = 1'b0;
                    state_d   = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    if (write_q) begin
                        data_d[idx_q]  = merged_line;
                        dirty_d[idx_q] = 1'b1;
                    end
                    state_d = StIdle;
                end else if (victim_dirty) begin
                    state_d = StWb;
                end else begin
                    state_d = StRreq;
                end
            end
            StWb: begin
                if (mem_w_ready) begin
                    state_d = flush_q ? StFlushNext : StRreq;
                end
            end
            StRreq: begin
                if (mem_r_ready) begin
                    state_d = StRwait;
                end
            end
            StRwait: begin
                if (mem_rdata_valid) begin
                    data_d[idx_q]  = mem_rdata;
                    tag_d[idx_q]   = req_tag_q;
                    valid_d[idx_q] = 1'b1;
                    dirty_d[idx_q] = 1'b0;
                    replay_d       = 1'b1;
                    state_d        = StCompare;
                end
            end
            StFlush: begin
                state_d = victim_dirty ? StWb : StFlushNext;
            end
            StFlushNext: begin
                valid_d[idx_q] = 1'b0;
                dirty_d[idx_q] = 1'b0;
                if (idx_q == LAST_IDX) begin
                    flush_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StFlush;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            dirty_q   <= '0;
            idx_q     <= '0;
            req_tag_q <= '0;
            wsel_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            flush_q   <= 1'b0;
            replay_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_LINES); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            idx_q     <= idx_d;
            req_tag_q <= req_tag_d;
            wsel_q    <= wsel_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            flush_q   <= flush_d;
            replay_q  <= replay_d;
        end
    end

    // Every handshake output decodes flops only, so no ready feeds back into a valid.
    assign cpu_req_ready  = (state_q == StIdle);
    assign cpu_resp_valid = (state_q == StCompare) && hit;
    assign cpu_resp_rdata = cpu_resp_valid ? (write_q ? merged_word : cur_word) : '0;
    assign cpu_resp_hit   = cpu_resp_valid && !replay_q;
    assign cpu_flush_done = (state_q == StFlushNext) && (idx_q == LAST_IDX);

    assign mem_w_valid = (state_q == StWb);
    assign mem_w_addr  = mem_w_valid ? {tag_q[idx_q], idx_q, {OFFSET_WIDTH{1'b0}}} : '0;
    assign mem_w_data  = mem_w_valid ? cur_line : '0;
    assign mem_w_wmask = {(1<<OFFSET_WIDTH){mem_w_valid}};
    assign mem_r_valid = (state_q == StRreq);
    assign mem_r_addr  = mem_r_valid ? {req_tag_q, idx_q, {OFFSET_WIDTH{1'b0}}} : '0;

endmodule

// File: tb/tb_cache_dm_wb.sv
// Directed bench for cache_dm_wb: response scoreboard, line-memory model, and mem-port log.
`timescale 1ns/1ps

module tb_cache_dm_wb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_ready;
    logic [31:0]  cpu_req_addr = '0;
    logic         cpu_req_write = 1'b0;
    logic [31:0]  cpu_req_wdata = '0;
    logic [3:0]   cpu_req_wmask = '0;
    logic         cpu_flush = 1'b0;
    logic         cpu_flush_done;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_rdata;
    logic         cpu_resp_hit;
    logic         mem_w_valid;
    logic         mem_w_ready = 1'b0;
    logic [31:0]  mem_w_addr;
    logic [127:0] mem_w_data;
    logic [15:0]  mem_w_wmask;
    logic         mem_r_valid;
    logic         mem_r_ready = 1'b0;
    logic [31:0]  mem_r_addr;
    logic         mem_rdata_valid = 1'b0;
    logic [127:0] mem_rdata = '0;

    cache_dm_wb dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_ready   (cpu_req_ready),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_write   (cpu_req_write),
        .cpu_req_wdata   (cpu_req_wdata),
        .cpu_req_wmask   (cpu_req_wmask),
        .cpu_flush       (cpu_flush),
        .cpu_flush_done  (cpu_flush_done),
        .cpu_resp_valid  (cpu_resp_valid),
        .cpu_resp_rdata  (cpu_resp_rdata),
        .cpu_resp_hit    (cpu_resp_hit),
        .mem_w_valid     (mem_w_valid),
        .mem_w_ready     (mem_w_ready),
        .mem_w_addr      (mem_w_addr),
        .mem_w_data      (mem_w_data),
        .mem_w_wmask     (mem_w_wmask),
        .mem_r_valid     (mem_r_valid),
        .mem_r_ready     (mem_r_ready),
        .mem_r_addr      (mem_r_addr),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
    } exp_t;

    typedef struct {
        logic         is_w;
        logic [31:0]  addr;
        logic [127:0] data;
    } ev_t;

    exp_t         exp_q[$];
    ev_t          ev_q[$];
    logic [127:0] mem_model [logic [31:0]];

    int n_pass = 0, n_fail = 0, n_total = 0;
    int resp_cnt = 0, done_cnt = 0, overlap_cnt = 0;
    int w_stall = 0, stall_seen = 0, unstable_cnt = 0, rdy_bad_cnt = 0;
    bit hold_rdata = 1'b0;
    bit rd_pending = 1'b0;
    logic [127:0] rd_line;
    logic [31:0]  ref_addr;
    logic [127:0] ref_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input logic is_w,
                            input logic [31:0] addr, input logic [127:0] data);
        if (ev_q.size() > idx) begin
            check({tag, "_kind"}, ev_q[idx].is_w, is_w);
            check({tag, "_addr"}, ev_q[idx].addr, addr);
            if (is_w) check({tag, "_data"}, ev_q[idx].data, data);
        end else begin
            check({tag, "_present"}, ev_q.size(), idx + 1);
        end
    endtask

    // Response scoreboard and flush-done counter.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (cpu_flush_done) done_cnt++;
            if (cpu_resp_valid) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", cpu_resp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", cpu_resp_rdata, e.rdata);
                    check("resp_hit", cpu_resp_hit, e.hit);
                end
            end
        end
    end

    // Line memory: answers write-backs (with optional stall) and refills, logging each.
    always @(negedge clk) begin : mem_resp
        if (rst) begin
            mem_w_ready     = 1'b0;
            mem_r_ready     = 1'b0;
            mem_rdata_valid = 1'b0;
            rd_pending      = 1'b0;
        end else begin
            mem_rdata_valid = 1'b0;
            if (rd_pending && !hold_rdata) begin
                mem_rdata_valid = 1'b1;
                mem_rdata       = rd_line;
                rd_pending      = 1'b0;
            end
            if (mem_w_valid && mem_r_valid) overlap_cnt++;
            if (mem_w_valid) begin
                if (w_stall > 0) begin
                    mem_w_ready = 1'b0;
                    w_stall--;
                    if (stall_seen == 0) begin
                        ref_addr = mem_w_addr;
                        ref_data = mem_w_data;
                    end else if (mem_w_addr !== ref_addr || mem_w_data !== ref_data) begin
                        unstable_cnt++;
                    end
                    if (cpu_req_ready !== 1'b0) rdy_bad_cnt++;
                    stall_seen++;
                end else begin
                    mem_w_ready = 1'b1;
                    mem_model[mem_w_addr] = mem_w_data;
                    ev_q.push_back('{is_w: 1'b1, addr: mem_w_addr, data: mem_w_data});
                end
            end else begin
                mem_w_ready = 1'b0;
            end
            if (mem_r_valid) begin
                mem_r_ready = 1'b1;
                rd_line     = mem_model.exists(mem_r_addr) ? mem_model[mem_r_addr] : '0;
                rd_pending  = 1'b1;
                ev_q.push_back('{is_w: 1'b0, addr: mem_r_addr, data: '0});
            end else begin
                mem_r_ready = 1'b0;
            end
        end
    end

    task automatic cpu_op(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] wm, input logic [31:0] exp_rdata,
                          input logic exp_hit);
        int   k;
        int   n0;
        exp_t e;
        k = 0;
        @(negedge clk);
        while (!cpu_req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", cpu_req_ready, 1'b1);
        e.rdata = exp_rdata;
        e.hit   = exp_hit;
        exp_q.push_back(e);
        n0 = resp_cnt;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        cpu_req_write = wr;
        cpu_req_wdata = wd;
        cpu_req_wmask = wm;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        if (exp_hit) check("hit_latency", cpu_resp_valid, 1'b1);
        k = 0;
        while (resp_cnt == n0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("resp_timeout", resp_cnt != n0, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        int d0;
        int k;
        mem_model[32'h40] = 128'h00004444_00003333_00002222_00001111;
        mem_model[32'h80] = 128'h88888888_77777777_66666666_55555555;
        mem_model[32'h70] = 128'h00000000_00000000_00000000_70707070;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", cpu_req_ready, 1'b1);
        check("rst_resp_valid", cpu_resp_valid, 1'b0);
        check("rst_resp_rdata", cpu_resp_rdata, 32'h0);
        check("rst_w_valid", mem_w_valid, 1'b0);
        check("rst_r_valid", mem_r_valid, 1'b0);
        check("rst_r_addr", mem_r_addr, 32'h0);
        check("rst_flush_done", cpu_flush_done, 1'b0);
        rst = 1'b0;

        // 1: cold miss then hit in the refilled line
        ev_q.delete();
        cpu_op(32'h40, 1'b0, '0, 4'h0, 32'h00001111, 1'b0);
        check_ev("t1_refill", 0, 1'b0, 32'h40, '0);
        cpu_op(32'h44, 1'b0, '0, 4'h0, 32'h00002222, 1'b1);

        // 2: masked store hit, then readback of merged word
        cpu_op(32'h44, 1'b1, 32'hDEADBEEF, 4'b0011, 32'h0000BEEF, 1'b1);
        cpu_op(32'h44, 1'b0, '0, 4'h0, 32'h0000BEEF, 1'b1);

        // 3: conflict miss evicts the dirty line before the refill
        ev_q.delete();
        cpu_op(32'h80, 1'b0, '0, 4'h0, 32'h55555555, 1'b0);
        check("t3_ev_cnt", ev_q.size(), 2);
        check_ev("t3_wb", 0, 1'b1, 32'h40, 128'h00004444_00003333_0000BEEF_00001111);
        check_ev("t3_refill", 1, 1'b0, 32'h80, '0);
        check("t3_no_overlap", overlap_cnt, 0);

        // 4: stalled write-back keeps its payload stable and blocks new requests
        cpu_op(32'h80, 1'b1, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b1);
        ev_q.delete();
        stall_seen = 0;
        unstable_cnt = 0;
        rdy_bad_cnt = 0;
        w_stall = 5;
        cpu_op(32'h40, 1'b0, '0, 4'h0, 32'h00001111, 1'b0);
        check("t4_stall_cycles", stall_seen, 5);
        check("t4_unstable", unstable_cnt, 0);
        check("t4_ready_in_wb", rdy_bad_cnt, 0);
        check_ev("t4_wb", 0, 1'b1, 32'h80, 128'h88888888_77777777_66666666_CAFEF00D);
        check_ev("t4_refill", 1, 1'b0, 32'h40, '0);

        // 5: flush with lines 0 and 2 dirty, line 1 clean, line 3 invalid
        cpu_op(32'h40, 1'b1, 32'hA5A5A5A5, 4'b1111, 32'hA5A5A5A5, 1'b1);
        cpu_op(32'h50, 1'b0, '0, 4'h0, 32'h00000000, 1'b0);
        cpu_op(32'h60, 1'b1, 32'h12345678, 4'b1111, 32'h12345678, 1'b0);
        ev_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        cpu_flush = 1'b1;
        @(negedge clk);
        cpu_flush = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check("t5_done_pulses", done_cnt - d0, 1);
        check("t5_ev_cnt", ev_q.size(), 2);
        check_ev("t5_wb0", 0, 1'b1, 32'h40, 128'h00004444_00003333_0000BEEF_A5A5A5A5);
        check_ev("t5_wb2", 1, 1'b1, 32'h60, 128'h00000000_00000000_00000000_12345678);
        cpu_op(32'h40, 1'b0, '0, 4'h0, 32'hA5A5A5A5, 1'b0);
        check_ev("t5_post_refill", 2, 1'b0, 32'h40, '0);

        // 6: reset while waiting for refill data abandons the request
        ev_q.delete();
        hold_rdata = 1'b1;
        n0 = resp_cnt;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h70;
        cpu_req_write = 1'b0;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        k = 0;
        while (ev_q.size() == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_rreq_seen", ev_q.size() > 0, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_r_valid", mem_r_valid, 1'b0);
        check("t6_req_ready", cpu_req_ready, 1'b1);
        check("t6_resp_valid", cpu_resp_valid, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        hold_rdata = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_no_resp", resp_cnt, n0);
        ev_q.delete();
        cpu_op(32'h70, 1'b0, '0, 4'h0, 32'h70707070, 1'b0);
        check_ev("t6_refill", 0, 1'b0, 32'h70, '0);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
